uart_rx_byte: RTL
=================

# uart_rx_byte

UART receiver for the team's 10 MHz serial path: samples the asynchronous `rx_in` line and recovers 8N1 frames at 31 250 baud. It delivers each byte with a one-cycle valid strobe and flags framing errors. It is the receive-side counterpart to the transmit path that the UART bit-period divider paces. The block keeps its own bit-period timer because it must re-phase that timer to each start edge and sample at mid-bit.

## Interface
- `CLKS_PER_BIT`, default 320: MHz10 cycles per bit. Minimum 4, must be even.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (160): start-bit mid-point delay.

Ports:
- `MHz10`, in, 1: 10 MHz system clock. All logic is on its rising edge.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: receiver enable.
- `rx_in`, in, 1: asynchronous serial line, idle high.
- `rx_data`, out, 8: last good byte, held until the next good byte.
- `rx_valid`, out, 1: one-cycle strobe, `rx_data` newly updated.
- `frame_err`, out, 1: one-cycle strobe, stop bit sampled low.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- **Synchronizer:** 2-flop synchronizer on `rx_in`, both flops reset to 1. The FSM sees only the synchronized `rx_s`.
- **Timer:** 9-bit up-counter `cnt`, cleared on every state transition.
- **IDLE:** when `rx_s==0`, go to START with `cnt=0`.
- **START:** when `cnt==HALF_BIT-1`:
  - `rx_s==0`: go to DATA, `bit_idx=0`.
  - `rx_s==1`: false start; return to IDLE with no strobe.
- **DATA:** when `cnt==CLKS_PER_BIT-1`, shift `rx_s` into the shift register LSB-first (`sh <= {rx_s, sh[7:1]}`) and increment `bit_idx`. After the sample with `bit_idx==7`, go to STOP (or PARITY when configured).
- **STOP:** when `cnt==CLKS_PER_BIT-1`:
  - `rx_s==1`: `rx_data<=sh`, pulse `rx_valid`, go to IDLE.
  - `rx_s==0`: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s==1`, then go to IDLE. A held-low line therefore never retriggers a start.
- **Enable:** `en==0` forces IDLE and `cnt=0` on the next edge, abandoning any frame in progress. `rx_data` holds, and no strobes fire.
- **Reset values:**
  - `rx_data=8'h00`, `rx_valid=0`, `frame_err=0`, `busy=0`.
  - State IDLE, `cnt=0`, `bit_idx=0`, `sh=0`.
- **Reset mid-frame:** aborts immediately. The receiver resyncs on the next start edge after release.
- **Exclusivity:** `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Stop-bit sample instant:** with edge E = the first edge at which `rx_in` low is captured by sync flop 1, the stop bit is sampled at edge E + 2 + HALF_BIT + 9·CLKS_PER_BIT = E+3042 for defaults.
- **Strobes:** `rx_valid` / `frame_err` are registered. They are high for exactly the one cycle following the stop-bit sample edge (from E+3042 for defaults).
- **Data sampling:** data bit k is sampled HALF_BIT + (k+1)·CLKS_PER_BIT cycles after START entry, i.e. at bit centre.
- **Back-to-back frames:** a start bit immediately after the stop-bit centre is accepted. The receiver is in IDLE half a bit before the next start edge.
- **Busy:** `busy` rises the cycle after START entry and falls the cycle after return to IDLE.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP, sampled at `cnt==CLKS_PER_BIT-1`. It expects even parity over the 8 data bits.
  - A mismatch sets an internal flag. At STOP, a flagged frame pulses `frame_err` instead of `rx_valid`, and `rx_data` is not updated. A valid stop bit then returns to IDLE rather than BREAK.
  - Strobe latency grows by CLKS_PER_BIT (E+3362 for defaults).
- **Undefined:** 8N1 only; no PARITY state exists.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constants `UART_CLKS_PER_BIT=320` and `UART_HALF_BIT=160`.
- **Sub-module `uart_rx_bit_timer`:** inputs clear and enable; outputs `at_half` and `at_full`; 9-bit counter. The FSM owns the synchronizer, shift register, `bit_idx` and output registers.

## Test plan
- **Single byte:** send 0x55 as 8N1 at 320 cycles/bit → `rx_data=0x55`, one `rx_valid` pulse at E+3042, `frame_err=0`.
- **Back-to-back:** 0xA3 then 0x0F with no idle gap → two `rx_valid` pulses 3200 cycles apart, data 0xA3 then 0x0F.
- **Glitch:** `rx_in` low for 100 cycles, then high → return to IDLE, no strobe, `busy` high for ~160 cycles only.
- **Framing error:** frame 0x3C with stop bit 0, line held low 2000 further cycles:
  - `frame_err` pulses once and `rx_data` keeps its prior value.
  - No new start is seen until the line rises; a following 0x81 is then received correctly.
- **Reset / enable abort:** `nrst` low during data bit 4 → all outputs 0 immediately. Separately, `en` dropped mid-frame → IDLE, no strobe, `rx_data` unchanged.
- **Parity (`UART_RX_PARITY_EN`):** 0x07 with parity bit 1 → `rx_valid` at E+3362. The same frame with parity bit 0 → `frame_err`, `rx_data` unchanged.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// Shared types and default timing for the 8N1 UART receiver.
// The receiver's PARITY state is only reachable with UART_RX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int UART_CLKS_PER_BIT = 320;
   localparam int UART_HALF_BIT     = 160;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial line plus byte/strobe outputs of the UART receiver.
// slave is the receiver side, master is the line driver and consumer.
interface uart_rx_byte_if;

   logic       en;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output en, rx_in,
      input  rx_data, rx_valid, frame_err, busy
   );

   modport slave (
      input  en, rx_in,
      output rx_data, rx_valid, frame_err, busy
   );

endinterface

// File: rtl/uart_rx_byte_bit_timer.sv
// Bit-period timer for the UART receiver: flags half-bit and full-bit
// points; the FSM clears it on every timing event to re-phase it.
module uart_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 320,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic MHz10,
   input  logic nrst,
   input  logic clear,
   input  logic enable,
   output logic at_half,
   output logic at_full
);

   localparam logic [8:0] HALF_M1 = 9'(HALF_BIT - 1);
   localparam logic [8:0] FULL_M1 = 9'(CLKS_PER_BIT - 1);

   logic [8:0] cnt;

   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) begin
         cnt <= 9'd0;
      end else if (clear) begin
         cnt <= 9'd0;
      end else if (enable) begin
         cnt <= cnt + 9'd1;
      end
   end

   assign at_half = (cnt == HALF_M1);
   assign at_full = (cnt == FULL_M1);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, mid-bit sampling, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit before stop.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic          MHz10,
   input  logic          nrst,
   uart_rx_byte_if.slave bus
);

   rx_state_t  state;
   logic       sync1;
   logic       rx_s;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;
   logic       at_half;
   logic       at_full;
   logic       ev;
   logic       clear;
`ifdef UART_RX_PARITY_EN
   logic       par_err;
`endif

   always_comb begin
      ev = 1'b0;
      case (state)
         IDLE:    ev = ~rx_s;
         START:   ev = at_half;
         BREAK:   ev = rx_s;
         default: ev = at_full;
      endcase
   end

   // Timer only runs while a frame is being timed.
   assign clear = ~bus.en | ev | (state == IDLE) | (state == BREAK);

   uart_rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .HALF_BIT     (HALF_BIT)
   ) u_timer (
      .MHz10   (MHz10),
      .nrst    (nrst),
      .clear   (clear),
      .enable  (bus.en),
      .at_half (at_half),
      .at_full (at_full)
   );

   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) begin
         sync1     <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         bit_idx   <= 3'd0;
         sh        <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         sync1     <= bus.rx_in;
         rx_s      <= sync1;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (!bus.en) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
               START: if (at_half) begin
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                     par_err <= 1'b0;
`endif
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               DATA: if (at_full) begin
                  sh      <= {rx_s, sh[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: if (at_full) begin
                  par_err <= ^{sh, rx_s};
                  state   <= STOP;
               end
`endif
               STOP: if (at_full) begin
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_err) begin
                        frame_err <= 1'b1;
                     end else begin
                        rx_data  <= sh;
                        rx_valid <= 1'b1;
                     end
`else
                     rx_data  <= sh;
                     rx_valid <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end
               // Held-low line must rise before a new start counts.
               BREAK: if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.busy      = busy;

endmodule
